// File: rtl/xm23_pkg.sv
// Shared constants for the XM23 execution unit: ALU/byte-path op codes, PSW layout, BCD helper.
package xm23_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_ADDC = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_SUBC = 5'd3;
  localparam logic [4:0] OP_DADD = 5'd4;
  localparam logic [4:0] OP_CMP  = 5'd5;
  localparam logic [4:0] OP_XOR  = 5'd6;
  localparam logic [4:0] OP_AND  = 5'd7;
  localparam logic [4:0] OP_OR   = 5'd8;
  localparam logic [4:0] OP_BIT  = 5'd9;
  localparam logic [4:0] OP_BIC  = 5'd10;
  localparam logic [4:0] OP_BIS  = 5'd11;
  localparam logic [4:0] OP_MOV  = 5'd12;
  localparam logic [4:0] OP_SWAP = 5'd13;
  localparam logic [4:0] OP_SRA  = 5'd14;
  localparam logic [4:0] OP_RRC  = 5'd15;
  localparam logic [4:0] OP_SWPB = 5'd16;
  localparam logic [4:0] OP_SXT  = 5'd17;

  localparam logic [2:0] BM_MOVL  = 3'd0;
  localparam logic [2:0] BM_MOVLZ = 3'd1;
  localparam logic [2:0] BM_MOVLS = 3'd2;
  localparam logic [2:0] BM_MOVH  = 3'd3;

  localparam int unsigned PSW_C   = 0;
  localparam int unsigned PSW_Z   = 1;
  localparam int unsigned PSW_N   = 2;
  localparam int unsigned PSW_SLP = 3;
  localparam int unsigned PSW_V   = 4;

  localparam logic [15:0] PSW_RESET = 16'h60E0;

  // Nibble-serial BCD add; returns {decimal carry, sum}. Byte mode stops after two nibbles.
  function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic byte_mode);
    logic [15:0] r;
    logic        c;
    logic [4:0]  t;
    r = '0;
    c = cin;
    for (int i = 0; i < 4; i++) begin
      if (!byte_mode || i < 2) begin
        t = {1'b0, a[4*i+:4]} + {1'b0, b[4*i+:4]} + {4'b0000, c};
        if (t > 5'd9) begin
          t = t + 5'd6;
          c = 1'b1;
        end else begin
          c = 1'b0;
        end
        r[4*i+:4] = t[3:0];
      end
    end
    return {c, r};
  endfunction

endpackage

// File: rtl/xm23_bm_unit.sv
// Registered byte-manipulation path for the immediate-load instructions (MOVL/MOVLZ/MOVLS/MOVH).
module xm23_bm_unit
  import xm23_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  op_i,
  input  logic [15:0] dst_i,
  input  logic [7:0]  imm_i,
  input  logic        en_i,
  output logic [15:0] out_o
);

  logic [15:0] out_d, out_q;

  always_comb begin
    out_d = dst_i;
    case (op_i)
      BM_MOVL:  out_d = {dst_i[15:8], imm_i};
      BM_MOVLZ: out_d = {8'h00, imm_i};
      BM_MOVLS: out_d = {8'hFF, imm_i};
      BM_MOVH:  out_d = {imm_i, dst_i[7:0]};
      default:  out_d = dst_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q <= '0;
    end else if (en_i) begin
      out_q <= out_d;
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/xm23_exec_unit.sv
// XM23 execution unit: registered 16-bit ALU with PSW flag generation plus the byte path.
module xm23_exec_unit
  import xm23_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] d_bus,
  input  logic [15:0] s_bus,
  input  logic [5:0]  alu_op,
  input  logic        alu_E,
  input  logic        psw_update,
  input  logic [15:0] psw_in,
  output logic [15:0] alu_out,
  output logic [15:0] psw_out,
  input  logic [2:0]  bm_op,
  input  logic [15:0] bm_in,
  input  logic [7:0]  ImByte,
  input  logic        bm_E,
  output logic [15:0] bm_out
);

  logic [4:0]  op;
  logic        byte_op;
  logic        cin;
  logic [15:0] b_eff, r, alu_d, psw_d, alu_q, psw_q;
  logic [16:0] sum_w, bcd;
  logic [8:0]  sum_b;
  logic        c_new, v_new, zn_upd, d_msb, b_msb, r_msb;

  assign op = alu_op[4:0];
  // SWPB and SXT are word-only regardless of the byte bit.
  assign byte_op = alu_op[5] && (op != OP_SWPB) && (op != OP_SXT);

  always_comb begin
    b_eff = (op == OP_SUB || op == OP_SUBC || op == OP_CMP) ? ~s_bus : s_bus;
    case (op)
      OP_ADDC, OP_SUBC, OP_DADD: cin = psw_in[PSW_C];
      OP_SUB, OP_CMP:            cin = 1'b1;
      default:                   cin = 1'b0;
    endcase
  end

  assign sum_w = {1'b0, d_bus} + {1'b0, b_eff} + {16'd0, cin};
  assign sum_b = {1'b0, d_bus[7:0]} + {1'b0, b_eff[7:0]} + {8'd0, cin};
  assign bcd   = bcd_add(d_bus, s_bus, cin, byte_op);

  always_comb begin
    r      = d_bus;
    c_new  = psw_in[PSW_C];
    v_new  = psw_in[PSW_V];
    zn_upd = 1'b0;
    d_msb  = byte_op ? d_bus[7] : d_bus[15];
    b_msb  = byte_op ? b_eff[7] : b_eff[15];
    case (op)
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP: begin
        r      = byte_op ? {8'h00, sum_b[7:0]} : sum_w[15:0];
        c_new  = byte_op ? sum_b[8] : sum_w[16];
        zn_upd = 1'b1;
      end
      OP_DADD: begin
        r      = bcd[15:0];
        c_new  = bcd[16];
        zn_upd = 1'b1;
      end
      OP_XOR:         begin r = d_bus ^ s_bus;  zn_upd = 1'b1; end
      OP_AND, OP_BIT: begin r = d_bus & s_bus;  zn_upd = 1'b1; end
      OP_OR, OP_BIS:  begin r = d_bus | s_bus;  zn_upd = 1'b1; end
      OP_BIC:         begin r = d_bus & ~s_bus; zn_upd = 1'b1; end
      OP_MOV, OP_SWAP: r = s_bus;
      OP_SRA: begin
        r      = byte_op ? {8'h00, d_bus[7], d_bus[7:1]} : {d_bus[15], d_bus[15:1]};
        c_new  = d_bus[0];
        zn_upd = 1'b1;
      end
      OP_RRC: begin
        r      = byte_op ? {8'h00, psw_in[PSW_C], d_bus[7:1]} : {psw_in[PSW_C], d_bus[15:1]};
        c_new  = d_bus[0];
        zn_upd = 1'b1;
      end
      OP_SWPB: begin r = {d_bus[7:0], d_bus[15:8]};     zn_upd = 1'b1; end
      OP_SXT:  begin r = {{8{d_bus[7]}}, d_bus[7:0]};   zn_upd = 1'b1; end
      default: r = d_bus;
    endcase
    r_msb = byte_op ? r[7] : r[15];
    if (op <= OP_CMP) begin
      v_new = (d_msb == b_msb) && (r_msb != d_msb);
    end

    if (op == OP_CMP || op == OP_BIT || op > OP_SXT) begin
      alu_d = d_bus;
    end else if (byte_op) begin
      alu_d = {d_bus[15:8], r[7:0]};
    end else begin
      alu_d = r;
    end

    psw_d = psw_in;
    if (psw_update) begin
      psw_d[PSW_C] = c_new;
      psw_d[PSW_V] = v_new;
      if (zn_upd) begin
        psw_d[PSW_Z] = byte_op ? (r[7:0] == 8'h00) : (r == 16'h0000);
        psw_d[PSW_N] = r_msb;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      alu_q <= '0;
      psw_q <= PSW_RESET;
    end else if (alu_E) begin
      alu_q <= alu_d;
      psw_q <= psw_d;
    end
  end

  assign alu_out = alu_q;
  assign psw_out = psw_q;

  xm23_bm_unit u_bm_unit (
    .clk_i (Clock),
    .rst_i (Reset),
    .op_i  (bm_op),
    .dst_i (bm_in),
    .imm_i (ImByte),
    .en_i  (bm_E),
    .out_o (bm_out)
  );

endmodule

// File: tb/tb_xm23_exec_unit.sv
// Directed self-checking bench for xm23_exec_unit with hand-computed expected values.
module tb_xm23_exec_unit;

  logic        Clock;
  logic        Reset;
  logic [15:0] d_bus, s_bus, psw_in, bm_in;
  logic [5:0]  alu_op;
  logic        alu_E, psw_update, bm_E;
  logic [2:0]  bm_op;
  logic [7:0]  ImByte;
  logic [15:0] alu_out, psw_out, bm_out;

  int n_checks = 0;
  int n_fail   = 0;

  xm23_exec_unit dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .d_bus      (d_bus),
    .s_bus      (s_bus),
    .alu_op     (alu_op),
    .alu_E      (alu_E),
    .psw_update (psw_update),
    .psw_in     (psw_in),
    .alu_out    (alu_out),
    .psw_out    (psw_out),
    .bm_op      (bm_op),
    .bm_in      (bm_in),
    .ImByte     (ImByte),
    .bm_E       (bm_E),
    .bm_out     (bm_out)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic alu_vec(input string tag, input logic [5:0] op, input logic [15:0] d,
                         input logic [15:0] s, input logic [15:0] pin, input logic upd,
                         input logic [15:0] exp_out, input logic [15:0] exp_psw);
    alu_op     = op;
    d_bus      = d;
    s_bus      = s;
    psw_in     = pin;
    psw_update = upd;
    alu_E      = 1'b1;
    step();
    alu_E = 1'b0;
    check({tag, ".out"}, alu_out, exp_out);
    check({tag, ".psw"}, psw_out, exp_psw);
  endtask

  task automatic bm_vec(input string tag, input logic [2:0] op, input logic en,
                        input logic [15:0] exp_out);
    bm_op = op;
    bm_E  = en;
    step();
    bm_E = 1'b0;
    check(tag, bm_out, exp_out);
  endtask

  initial begin
    // Reset with both enables high and junk operands: reset must win.
    Reset      = 1'b1;
    d_bus      = 16'h1234;
    s_bus      = 16'h4321;
    alu_op     = 6'd0;
    alu_E      = 1'b1;
    psw_update = 1'b1;
    psw_in     = 16'hFFFF;
    bm_op      = 3'd1;
    bm_in      = 16'h5555;
    ImByte     = 8'h77;
    bm_E       = 1'b1;
    step();
    check("reset.alu", alu_out, 16'h0000);
    check("reset.bm",  bm_out,  16'h0000);
    check("reset.psw", psw_out, 16'h60E0);
    Reset = 1'b0;
    alu_E = 1'b0;
    bm_E  = 1'b0;

    //      tag         op     D         S         psw_in    upd   out       psw
    alu_vec("add_ovf",  6'd0,  16'h7FFF, 16'h0001, 16'hA008, 1'b1, 16'h8000, 16'hA01C);
    alu_vec("cmp_b",    6'd37, 16'h12FF, 16'h00FF, 16'h0000, 1'b1, 16'h12FF, 16'h0003);
    alu_vec("dadd1",    6'd4,  16'h0099, 16'h0001, 16'h0010, 1'b1, 16'h0100, 16'h0000);
    alu_vec("dadd2",    6'd4,  16'h9999, 16'h0001, 16'h0000, 1'b1, 16'h0000, 16'h0003);
    alu_vec("rrc",      6'd15, 16'h0002, 16'h0000, 16'h0001, 1'b1, 16'h8001, 16'h0004);
    alu_vec("sra",      6'd14, 16'h8001, 16'h0000, 16'h0010, 1'b1, 16'hC000, 16'h0015);
    alu_vec("sub_brw",  6'd2,  16'h0005, 16'h0007, 16'h0000, 1'b1, 16'hFFFE, 16'h0004);
    alu_vec("addc_b",   6'd33, 16'h34F0, 16'h0010, 16'h0015, 1'b1, 16'h3401, 16'h0001);
    alu_vec("and_z",    6'd7,  16'hF0F0, 16'h0F0F, 16'h0011, 1'b1, 16'h0000, 16'h0013);
    alu_vec("xor_b",    6'd38, 16'h12F0, 16'h34F0, 16'h0011, 1'b1, 16'h1200, 16'h0013);
    alu_vec("sxt_b",    6'd49, 16'h1280, 16'h0000, 16'h0000, 1'b1, 16'hFF80, 16'h0004);
    alu_vec("swpb_b",   6'd48, 16'h1234, 16'h0000, 16'h0000, 1'b1, 16'h3412, 16'h0000);
    alu_vec("mov_b",    6'd44, 16'h1234, 16'hABCD, 16'h0017, 1'b1, 16'h12CD, 16'h0017);
    alu_vec("no_upd",   6'd2,  16'h0000, 16'h0001, 16'h1234, 1'b0, 16'hFFFF, 16'h1234);
    alu_vec("op20",     6'd20, 16'h5555, 16'h0001, 16'h0002, 1'b1, 16'h5555, 16'h0002);

    // alu_E low: registered result and PSW must hold.
    alu_op     = 6'd0;
    d_bus      = 16'h1111;
    s_bus      = 16'h2222;
    psw_in     = 16'hFFFF;
    psw_update = 1'b1;
    step();
    check("hold.alu", alu_out, 16'h5555);
    check("hold.psw", psw_out, 16'h0002);
    check("hold.bm",  bm_out,  16'h0000);

    bm_in  = 16'hABCD;
    ImByte = 8'h5A;
    bm_vec("movl",    3'd0, 1'b1, 16'hAB5A);
    bm_vec("movlz",   3'd1, 1'b1, 16'h005A);
    bm_vec("movls",   3'd2, 1'b1, 16'hFF5A);
    bm_vec("movh",    3'd3, 1'b1, 16'h5ACD);
    bm_vec("bm_hold", 3'd1, 1'b0, 16'h5ACD);
    bm_vec("bm_op6",  3'd6, 1'b1, 16'hABCD);

    // Both paths enabled together.
    alu_op = 6'd0;
    d_bus  = 16'h0001;
    s_bus  = 16'h0002;
    psw_in = 16'h0000;
    alu_E  = 1'b1;
    bm_op  = 3'd1;
    bm_E   = 1'b1;
    step();
    check("both.alu", alu_out, 16'h0003);
    check("both.bm",  bm_out,  16'h005A);

    // Reset in the same cycle as enables.
    Reset  = 1'b1;
    alu_op = 6'd0;
    d_bus  = 16'h7777;
    step();
    Reset = 1'b0;
    alu_E = 1'b0;
    bm_E  = 1'b0;
    check("rst2.alu", alu_out, 16'h0000);
    check("rst2.bm",  bm_out,  16'h0000);
    check("rst2.psw", psw_out, 16'h60E0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
